// File: rtl/dlsc_demosaic_vng6_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dlsc_demosaic_vng6_seq_pkg                                      |
// | Purpose  : Shared types, constants and helpers for the VNG6 demosaic       |
// |            sequencer: FSM encoding, phase wrap value, default phase masks. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package dlsc_demosaic_vng6_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_RUN   = 2'd1,
    SEQ_DRAIN = 2'd2
  } seq_state_t;

  localparam logic [3:0]  ST_LAST       = 4'd11;
  localparam logic [11:0] DEF_PUSH_MASK = 12'h041;
  localparam logic [11:0] DEF_OUT_MASK  = 12'h820;

  // Next phase in the 12-phase rotation.
  function automatic logic [3:0] st_advance(input logic [3:0] st);
    return (st == ST_LAST) ? 4'd0 : st + 4'd1;
  endfunction

  // Phase-mask lookup; the mask is widened so any 4-bit phase indexes in range.
  function automatic logic mask_bit(input logic [11:0] mask, input logic [3:0] st);
    logic [15:0] m;
    m = {4'd0, mask};
    return m[st];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dlsc_demosaic_vng6_credits.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dlsc_demosaic_vng6_credits                                      |
// | Purpose  : Output-FIFO credit counter. Starts full, one credit taken per   |
// |            result launch, one returned per FIFO pop; saturates at CREDITS. |
// | Ports    : clk, rst_n   clock / async active-low reset                     |
// |            i_take       a result is launched this cycle                    |
// |            i_give       downstream popped one entry                        |
// |            o_empty      no credit left (launches must stall)               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dlsc_demosaic_vng6_credits #(
  parameter int CREDITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_take,
  input  logic i_give,
  output logic o_empty
);

  localparam int             C_CW   = $clog2(CREDITS + 1);
  localparam logic [C_CW-1:0] C_FULL = C_CW'(CREDITS);

  logic [C_CW-1:0] credits_q;
  logic [C_CW-1:0] credits_d;

  always_comb begin
    credits_d = credits_q;
    // Simultaneous take and give cancel; a give while already full is dropped.
    if (i_take && !i_give) begin
      credits_d = credits_q - 1'b1;
    end else if (i_give && !i_take && (credits_q != C_FULL)) begin
      credits_d = credits_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= C_FULL;
    end else begin
      credits_q <= credits_d;
    end
  end

  assign o_empty = (credits_q == '0);

endmodule
`default_nettype wire

// File: rtl/dlsc_demosaic_vng6_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dlsc_demosaic_vng6_seq                                          |
// | Purpose  : Sequencer for the VNG6 demosaic datapath. Generates the shared  |
// |            12-phase st, clk_en and px_push; gates input pixels; throttles  |
// |            result launches on output-FIFO credits; tracks row/column and   |
// |            drains the pipeline at end of frame.                            |
// | Ports    : cfg_enable/in_valid/in_data/in_ready   pixel input side         |
// |            clk_en/st/px_push/px_in               datapath control          |
// |            out_push/out_pop                      output FIFO handshake     |
// |            col_/row_first/last                   position of pushed pixel  |
// |            busy/done                             frame status              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module dlsc_demosaic_vng6_seq
  import dlsc_demosaic_vng6_seq_pkg::*;
#(
  parameter int          DATA      = 8,
  parameter int          WIDTH     = 640,
  parameter int          HEIGHT    = 480,
  parameter logic [11:0] PUSH_MASK = DEF_PUSH_MASK,
  parameter logic [11:0] OUT_MASK  = DEF_OUT_MASK,
  parameter int          LATENCY   = 24,
  parameter int          CREDITS   = 16,
  parameter int          DRAIN     = 48
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_enable,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DATA-1:0] in_data,
  output logic            clk_en,
  output logic [3:0]      st,
  output logic            px_push,
  output logic [DATA-1:0] px_in,
  output logic            out_push,
  input  logic            out_pop,
  output logic            col_first,
  output logic            col_last,
  output logic            row_first,
  output logic            row_last,
  output logic            busy,
  output logic            done
);

  localparam int                 C_COL_W    = $clog2(WIDTH);
  localparam int                 C_ROW_W    = $clog2(HEIGHT);
  localparam int                 C_DRN_W    = $clog2(DRAIN + 1);
  localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(WIDTH - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(HEIGHT - 1);
  localparam logic [C_DRN_W-1:0] C_DRN_LAST = C_DRN_W'(DRAIN - 1);

  seq_state_t          state_q, state_d;
  logic [3:0]          st_q, st_d;
  logic [C_COL_W-1:0]  col_q, col_d;
  logic [C_ROW_W-1:0]  row_q, row_d;
  logic [C_DRN_W-1:0]  drn_q, drn_d;
  logic [LATENCY-1:0]  dly_q, dly_d;
  logic [DATA-1:0]     px_in_q, px_in_d;
  logic                col_first_q, col_first_d;
  logic                col_last_q, col_last_d;
  logic                row_first_q, row_first_d;
  logic                row_last_q, row_last_d;
  logic                done_q, done_d;

  logic                w_push_slot;
  logic                w_out_slot;
  logic                w_cred_empty;
  logic                w_clk_en;
  logic                w_px_push;
  logic                w_launch;
  logic [LATENCY:0]    w_dly_shift;

  // Phase decode and stall conditions.
  always_comb begin
    w_push_slot = mask_bit(PUSH_MASK, st_q);
    w_out_slot  = mask_bit(OUT_MASK, st_q);
    case (state_q)
      SEQ_RUN:   w_clk_en = !(w_push_slot && !in_valid) && !(w_out_slot && w_cred_empty);
      SEQ_DRAIN: w_clk_en = !(w_out_slot && w_cred_empty);
      default:   w_clk_en = 1'b0;
    endcase
    w_px_push = w_clk_en && w_push_slot && (state_q == SEQ_RUN);
    w_launch  = w_clk_en && w_out_slot;
  end

  // The launch delay line only advances with the datapath, so a launch reaches
  // the output after exactly LATENCY enabled cycles regardless of stalls.
  assign w_dly_shift = {dly_q, w_out_slot};

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    col_d       = col_q;
    row_d       = row_q;
    drn_d       = drn_q;
    dly_d       = dly_q;
    px_in_d     = px_in_q;
    col_first_d = col_first_q;
    col_last_d  = col_last_q;
    row_first_d = row_first_q;
    row_last_d  = row_last_q;
    done_d      = 1'b0;

    if (w_clk_en) begin
      st_d  = st_advance(st_q);
      dly_d = w_dly_shift[LATENCY-1:0];
    end

    // Flags describe the pixel being handed to the datapath alongside px_in.
    if (w_px_push) begin
      px_in_d     = in_data;
      col_first_d = (col_q == '0);
      col_last_d  = (col_q == C_COL_LAST);
      row_first_d = (row_q == '0);
      row_last_d  = (row_q == C_ROW_LAST);
      if (col_q == C_COL_LAST) begin
        col_d = '0;
        row_d = (row_q == C_ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      SEQ_IDLE: begin
        st_d = 4'd0;
        if (cfg_enable && in_valid) begin
          state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (w_px_push && (col_q == C_COL_LAST) && (row_q == C_ROW_LAST)) begin
          state_d = SEQ_DRAIN;
          drn_d   = '0;
        end
      end
      SEQ_DRAIN: begin
        if (w_clk_en) begin
          if (drn_q == C_DRN_LAST) begin
            state_d = SEQ_IDLE;
            st_d    = 4'd0;
            drn_d   = '0;
            done_d  = 1'b1;
          end else begin
            drn_d = drn_q + 1'b1;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEQ_IDLE;
      st_q        <= 4'd0;
      col_q       <= '0;
      row_q       <= '0;
      drn_q       <= '0;
      dly_q       <= '0;
      px_in_q     <= '0;
      col_first_q <= 1'b0;
      col_last_q  <= 1'b0;
      row_first_q <= 1'b0;
      row_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      col_q       <= col_d;
      row_q       <= row_d;
      drn_q       <= drn_d;
      dly_q       <= dly_d;
      px_in_q     <= px_in_d;
      col_first_q <= col_first_d;
      col_last_q  <= col_last_d;
      row_first_q <= row_first_d;
      row_last_q  <= row_last_d;
      done_q      <= done_d;
    end
  end

  dlsc_demosaic_vng6_credits #(
    .CREDITS (CREDITS)
  ) u_credits (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_take  (w_launch),
    .i_give  (out_pop),
    .o_empty (w_cred_empty)
  );

  assign in_ready  = w_px_push;
  assign clk_en    = w_clk_en;
  assign st        = st_q;
  assign px_push   = w_px_push;
  assign px_in     = px_in_q;
  assign out_push  = w_clk_en && dly_q[LATENCY-1];
  assign col_first = col_first_q;
  assign col_last  = col_last_q;
  assign row_first = row_first_q;
  assign row_last  = row_last_q;
  assign busy      = (state_q != SEQ_IDLE);
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dlsc_demosaic_vng6_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dlsc_demosaic_vng6_seq                                       |
// | Purpose  : Self-checking bench. Instance A (CREDITS=16, FIFO pops mirror   |
// |            results) covers reset, full frames, input stalls and cfg drop;  |
// |            instance B (CREDITS=2, manual pops) covers credit throttling.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dlsc_demosaic_vng6_seq;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic       a_rst_n, a_cfg_enable, a_in_valid, a_in_ready, a_clk_en, a_px_push;
  logic       a_out_push, a_out_pop, a_col_first, a_col_last, a_row_first, a_row_last;
  logic       a_busy, a_done, a_mirror;
  logic [7:0] a_in_data, a_px_in;
  logic [3:0] a_st;
  // Instance B
  logic       b_rst_n, b_cfg_enable, b_in_valid, b_in_ready, b_clk_en, b_px_push;
  logic       b_out_push, b_out_pop, b_col_first, b_col_last, b_row_first, b_row_last;
  logic       b_busy, b_done;
  logic [7:0] b_in_data, b_px_in;
  logic [3:0] b_st;

  assign a_out_pop = a_out_push & a_mirror;

  dlsc_demosaic_vng6_seq #(
    .DATA(8), .WIDTH(W), .HEIGHT(H), .PUSH_MASK(12'h041), .OUT_MASK(12'h820),
    .LATENCY(24), .CREDITS(16), .DRAIN(48)
  ) dut_a (
    .clk(clk), .rst_n(a_rst_n), .cfg_enable(a_cfg_enable), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_data(a_in_data), .clk_en(a_clk_en), .st(a_st),
    .px_push(a_px_push), .px_in(a_px_in), .out_push(a_out_push), .out_pop(a_out_pop),
    .col_first(a_col_first), .col_last(a_col_last), .row_first(a_row_first),
    .row_last(a_row_last), .busy(a_busy), .done(a_done)
  );

  dlsc_demosaic_vng6_seq #(
    .DATA(8), .WIDTH(W), .HEIGHT(H), .PUSH_MASK(12'h041), .OUT_MASK(12'h820),
    .LATENCY(24), .CREDITS(2), .DRAIN(48)
  ) dut_b (
    .clk(clk), .rst_n(b_rst_n), .cfg_enable(b_cfg_enable), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_data(b_in_data), .clk_en(b_clk_en), .st(b_st),
    .px_push(b_px_push), .px_in(b_px_in), .out_push(b_out_push), .out_pop(b_out_pop),
    .col_first(b_col_first), .col_last(b_col_last), .row_first(b_row_first),
    .row_last(b_row_last), .busy(b_busy), .done(b_done)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of pixels handed to the datapath
  typedef struct packed {
    logic [7:0] d;
    logic       cf;
    logic       cl;
    logic       rf;
    logic       rl;
  } pix_t;

  pix_t exp_q[$];
  int   a_k   = 0;   // pixel index within the current frame
  int   a_seq = 0;   // running pixel counter used as the data pattern
  logic want_valid_a = 1'b0, want_cfg_a = 1'b0;
  logic want_cfg_b = 1'b0, want_pop_b = 1'b0;

  // Monitor: px_in and flags are valid the cycle after a px_push.
  logic a_prev_push = 1'b0;
  always @(negedge clk) begin
    pix_t e;
    if (a_prev_push) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL px_unexpected: got px_in=%0h with no pixel expected", a_px_in);
      end else begin
        e = exp_q.pop_front();
        chk("px_in", int'(a_px_in), int'(e.d));
        chk("px_flags", int'({a_col_first, a_col_last, a_row_first, a_row_last}),
            int'({e.cf, e.cl, e.rf, e.rl}));
      end
    end
    a_prev_push <= a_px_push;
  end

  // One clock of instance A: inputs change just after the rising edge,
  // observation happens at the falling edge.
  task automatic step_a();
    pix_t e;
    int   col, row;
    @(posedge clk);
    #1;
    a_in_valid   = want_valid_a;
    a_cfg_enable = want_cfg_a;
    a_in_data    = 8'h30 + 8'(a_seq);
    @(negedge clk);
    if (a_in_ready) begin
      col  = a_k % W;
      row  = (a_k / W) % H;
      e.d  = a_in_data;
      e.cf = (col == 0);
      e.cl = (col == W - 1);
      e.rf = (row == 0);
      e.rl = (row == H - 1);
      exp_q.push_back(e);
      a_k++;
      a_seq++;
    end
  endtask

  task automatic step_b();
    @(posedge clk);
    #1;
    b_in_valid   = 1'b1;
    b_cfg_enable = want_cfg_b;
    b_out_pop    = want_pop_b;
    b_in_data    = 8'h00;
    @(negedge clk);
  endtask

  task automatic step_b_until(input logic [3:0] target);
    int n;
    n = 0;
    do begin
      step_b();
      n++;
    end while ((b_st != target) && (n < 40));
    chk("b_reach_st", int'(b_st), int'(target));
  endtask

  // Runs one frame on A. Launches sit at st 5/11; 43 RUN clk_en cycles plus 48
  // DRAIN cycles give launches at enabled-cycle 5,11,...,89, and those issued at
  // cycle <= 66 surface (+24) before IDLE: 11 out_push in a frame that starts
  // with an empty delay line.
  task automatic run_frame_a(input bit do_stall, input bit drop_early, input bit count_out);
    int  pushes, outs, drain_ce;
    bit  seen_done, stalled;
    pushes    = 0;
    outs      = 0;
    drain_ce  = 0;
    seen_done = 0;
    stalled   = 0;
    a_k          = 0;
    want_cfg_a   = 1'b1;
    want_valid_a = 1'b1;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      step_a();
      if (a_px_push) begin
        pushes++;
        chk("push_phase", int'((a_st == 4'd0) || (a_st == 4'd6)), 1);
      end
      if (a_out_push) outs++;
      if (a_clk_en && !a_px_push && (a_k == NPIX)) drain_ce++;
      if (a_k >= (drop_early ? 1 : NPIX)) want_cfg_a = 1'b0;
      if (do_stall && !stalled && (a_k == 2) && (a_st == 4'd5) && a_clk_en) begin
        stalled      = 1;
        want_valid_a = 1'b0;
        repeat (5) begin
          step_a();
          chk("stall_clk_en", int'(a_clk_en), 0);
          chk("stall_st", int'(a_st), 6);
        end
        want_valid_a = 1'b1;
        step_a();
        chk("resume_push", int'(a_px_push), 1);
        chk("resume_st", int'(a_st), 6);
        if (a_px_push) pushes++;
        if (a_out_push) outs++;
      end
      if (a_done) begin
        seen_done = 1;
        chk("done_busy", int'(a_busy), 0);
      end
    end
    chk("frame_done", int'(seen_done), 1);
    chk("frame_pushes", pushes, NPIX);
    chk("drain_clk_en", drain_ce, 48);
    if (count_out) chk("frame_out_push", outs, 11);
    step_a();
    chk("done_pulse_width", int'(a_done), 0);
    // IDLE must hold with cfg_enable low even though a pixel is offered.
    repeat (4) begin
      step_a();
      chk("idle_busy", int'(a_busy), 0);
      chk("idle_ready", int'(a_in_ready), 0);
      chk("idle_clk_en", int'(a_clk_en), 0);
      chk("idle_st", int'(a_st), 0);
    end
  endtask

  initial begin
    int ce;
    a_rst_n = 1'b0; a_cfg_enable = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00;
    a_mirror = 1'b1;
    b_rst_n = 1'b0; b_cfg_enable = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00;
    b_out_pop = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_clk_en", int'(a_clk_en), 0);
    chk("rst_st", int'(a_st), 0);
    chk("rst_px_push", int'(a_px_push), 0);
    chk("rst_out_push", int'(a_out_push), 0);
    chk("rst_px_in", int'(a_px_in), 0);
    chk("rst_done", int'(a_done), 0);
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;

    // Mid-RUN asynchronous reset at st=7
    want_cfg_a   = 1'b1;
    want_valid_a = 1'b1;
    ce = 0;
    do begin
      step_a();
      ce++;
    end while (!(a_busy && a_st == 4'd7) && ce < 30);
    chk("reach_st7", int'(a_st), 7);
    #1;
    a_rst_n      = 1'b0;
    want_cfg_a   = 1'b0;
    a_cfg_enable = 1'b0;
    #1;
    chk("async_rst_clk_en", int'(a_clk_en), 0);
    chk("async_rst_st", int'(a_st), 0);
    chk("async_rst_busy", int'(a_busy), 0);
    chk("async_rst_ready", int'(a_in_ready), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;

    // Frame with input stall and cfg_enable dropped mid-frame, then a second frame
    run_frame_a(1'b1, 1'b1, 1'b1);
    run_frame_a(1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);

    // Credit throttling on B (two credits, no pops)
    @(posedge clk);
    #1;
    b_rst_n    = 1'b1;
    want_cfg_b = 1'b1;
    want_pop_b = 1'b0;
    ce = 0;
    for (int n = 0; n < 100; n++) begin
      step_b();
      if (b_busy && !b_clk_en) break;
      if (b_clk_en) ce++;
    end
    want_cfg_b = 1'b0;
    chk("b_stall_st", int'(b_st), 5);
    chk("b_ce_before_stall", ce, 17);
    repeat (3) begin
      step_b();
      chk("b_hold_stall", int'(b_clk_en), 0);
    end
    want_pop_b = 1'b1;
    step_b();
    chk("b_pop_cycle_clk_en", int'(b_clk_en), 0);
    step_b();   // pop and launch together at one credit
    chk("b_release_clk_en", int'(b_clk_en), 1);
    chk("b_release_st", int'(b_st), 5);
    want_pop_b = 1'b0;
    step_b_until(4'd11);
    chk("b_both_keeps_credit", int'(b_clk_en), 1);
    step_b_until(4'd5);
    chk("b_stall_again", int'(b_clk_en), 0);
    // Five pops: one while stalled, one with a launch, three saturate at two.
    want_pop_b = 1'b1;
    repeat (5) step_b();
    want_pop_b = 1'b0;
    step_b_until(4'd11);
    chk("b_sat_first", int'(b_clk_en), 1);
    step_b_until(4'd5);
    chk("b_sat_second", int'(b_clk_en), 1);
    step_b_until(4'd11);
    chk("b_sat_stall", int'(b_clk_en), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
